alu_exec_unit: RTL and testbench

Execute-stage datapath directly downstream of the ALU control decoder: consumes its decoded `Op`, `Cin`, `inv1`, `inv2`, `err` together with two 16-bit operands, and produces a registered result plus Z/N/V flags. Add/logic ops complete in one cycle. Shifts and rotates run iteratively, one bit position per cycle, under a small FSM. Valid/ready handshakes on both sides let the pipeline stall around multi-cycle shifts.

---
 rtl/alu_pkg.sv | 14 +
 rtl/shift_step.sv | 14 +
 rtl/alu_exec_unit.sv | 122 ++++++++++++
 tb/tb_alu_exec_unit.sv | 138 +++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared width, opcode and state definitions for the execute stage
package alu_pkg;
    localparam int WIDTH   = 16;
    localparam int SHAMT_W = 4;
    localparam logic [2:0] OP_ROL = 3'b000;
    localparam logic [2:0] OP_SLL = 3'b001;
    localparam logic [2:0] OP_ROR = 3'b010;
    localparam logic [2:0] OP_SRA = 3'b011;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_AND = 3'b111;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} exec_state_t;
endpackage

// File: rtl/shift_step.sv
// shift_step: one-position ROL/SLL/ROR/SRA selected by the low opcode bits
module shift_step
    import alu_pkg::*;
(
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    always_comb
        dout = op == OP_ROL[1:0] ? {din[WIDTH-2:0], din[WIDTH-1]} :
               op == OP_SLL[1:0] ? {din[WIDTH-2:0], 1'b0} :
               op == OP_ROR[1:0] ? {din[0], din[WIDTH-1:1]} :
                                   {din[WIDTH-1], din[WIDTH-1:1]};
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute stage with single-cycle add/logic and iterative shifts
module alu_exec_unit
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       Op,
    input  logic             Cin,
    input  logic             inv1,
    input  logic             inv2,
    input  logic             err,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             Z,
    output logic             N,
    output logic             V,
    output logic             err_out
);
    exec_state_t state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d, shreg_q, shreg_d, stepped, a, b;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [1:0] sop_q, sop_d;
    logic z_q, z_d, n_q, n_d, v_q, v_d, err_q, err_d, ld;
    logic [WIDTH:0] sum;

    assign a   = inv1 ? ~A : A;
    assign b   = inv2 ? ~B : B;
    assign sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, Cin};

    shift_step u_step (.op(sop_q), .din(shreg_q), .dout(stepped));

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        sop_d    = sop_q;
        v_d      = v_q;
        err_d    = err_q;
        ld       = 1'b0;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    state_d = DONE;
                    ld      = 1'b1;
                    err_d   = err;
                    v_d     = 1'b0;
                    if (err) begin
                        result_d = '0;
                    end else if (Op[2]) begin
                        result_d = Op == OP_ADD ? sum[WIDTH-1:0] :
                                   Op == OP_OR  ? a | b :
                                   Op == OP_XOR ? a ^ b : a & b;
                        v_d = Op == OP_ADD && a[WIDTH-1] == b[WIDTH-1] && sum[WIDTH-1] != a[WIDTH-1];
                    end else if (B[SHAMT_W-1:0] == '0) begin
                        result_d = a;
                    end else begin
                        state_d = SHIFT;
                        ld      = 1'b0;
                        shreg_d = a;
                        cnt_d   = B[SHAMT_W-1:0];
                        sop_d   = Op[1:0];
                    end
                end
                SHIFT: begin
                    shreg_d = stepped;
                    cnt_d   = cnt_q - 1'b1;
                    if (cnt_q == 1) begin
                        state_d  = DONE;
                        result_d = stepped;
                        ld       = 1'b1;
                    end
                end
                DONE: if (out_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
        // flags only move when a new result is loaded so they stay stable in DONE
        z_d = ld ? result_d == '0 : z_q;
        n_d = ld ? result_d[WIDTH-1] : n_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            result_q <= '0;
            shreg_q  <= '0;
            cnt_q    <= '0;
            sop_q    <= '0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
            v_q      <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            sop_q    <= sop_d;
            z_q      <= z_d;
            n_q      <= n_d;
            v_q      <= v_d;
            err_q    <= err_d;
        end
    end

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign result    = result_q;
    assign Z         = z_q;
    assign N         = n_q;
    assign V         = v_q;
    assign err_out   = err_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed and random checks against an arithmetic reference model
module tb_alu_exec_unit;
    logic clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 0;
    logic Cin = 0, inv1 = 0, inv2 = 0, err = 0;
    logic [2:0] Op = 0;
    logic [15:0] A = 0, B = 0;
    logic in_ready, out_valid, Z, N, V, err_out;
    logic [15:0] result;
    int checks = 0, errors = 0;

    alu_exec_unit dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .Op(Op), .Cin(Cin), .inv1(inv1), .inv2(inv2), .err(err), .A(A), .B(B),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .Z(Z), .N(N), .V(V), .err_out(err_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model(input logic [2:0] op, input logic cin, i1, i2, e, input logic [15:0] ai, bi,
                         output logic [15:0] r, output logic v, output int lat);
        logic [15:0] a, b;
        logic [31:0] w;
        int k, s;
        a = i1 ? ~ai : ai;
        b = i2 ? ~bi : bi;
        k = int'(bi[3:0]);
        w = {16'b0, a};
        v = 0;
        lat = 1;
        if (e) r = 0;
        else case (op)
            3'b100: begin
                r = a + b + {15'b0, cin};
                s = int'($signed(a)) + int'($signed(b)) + int'(cin);
                v = s > 32767 || s < -32768;
            end
            3'b101: r = a | b;
            3'b110: r = a ^ b;
            3'b111: r = a & b;
            default: begin
                lat = k == 0 ? 1 : k + 1;
                case (op)
                    3'b000: r = 16'((w << k) | (w >> (16 - k)));
                    3'b001: r = 16'(w << k);
                    3'b010: r = 16'((w >> k) | (w << (16 - k)));
                    default: r = 16'($signed(a) >>> k);
                endcase
            end
        endcase
    endtask

    task automatic do_op(input string tag, input logic [2:0] op, input logic cin, i1, i2, e,
                         input logic [15:0] ai, bi, input int hold);
        logic [15:0] r, held;
        logic v;
        int lat, n;
        model(op, cin, i1, i2, e, ai, bi, r, v, lat);
        @(negedge clk);
        check({tag, " ready"}, in_ready, 1);
        Op = op; Cin = cin; inv1 = i1; inv2 = i2; err = e; A = ai; B = bi; in_valid = 1;
        @(negedge clk);
        in_valid = 0;
        n = 1;
        if (lat > 1) check({tag, " busy"}, in_ready, 0);
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, " latency"}, n, lat);
        check({tag, " result"}, result, r);
        check({tag, " Z"}, Z, r == 0);
        check({tag, " N"}, N, r[15]);
        check({tag, " V"}, V, v);
        check({tag, " err_out"}, err_out, e);
        held = result;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1;
            A = ~A;
            @(negedge clk);
            check({tag, " hold result"}, result, held);
            check({tag, " hold valid"}, {out_valid, in_ready}, 2'b10);
        end
        in_valid = 0;
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        check({tag, " handshake"}, {out_valid, in_ready}, 2'b01);
    endtask

    task automatic abort(input string tag, input bit use_flush, input int wait_n);
        @(negedge clk);
        Op = 3'b000; Cin = 0; inv1 = 0; inv2 = 0; err = 0; A = 16'h1357; B = 16'h000A; in_valid = 1;
        @(negedge clk);
        in_valid = 0;
        repeat (wait_n - 1) @(negedge clk);
        if (use_flush) flush = 1; else rst_n = 0;
        @(negedge clk);
        flush = 0;
        rst_n = 1;
        check({tag, " idle"}, {out_valid, in_ready}, 2'b01);
        if (!use_flush) check({tag, " outputs"}, {result, Z, N, V, err_out}, 20'h0);
        repeat (12) @(negedge clk);
        check({tag, " no late result"}, out_valid, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset", {in_ready, out_valid, result, Z, N, V, err_out}, {2'b10, 20'h0});
        rst_n = 1;
        do_op("add ovf", 3'b100, 0, 0, 0, 0, 16'h7FFF, 16'h0001, 0);
        do_op("sub", 3'b100, 1, 1, 0, 0, 16'h0005, 16'h0005, 0);
        do_op("and", 3'b111, 0, 0, 0, 0, 16'hF0F0, 16'h0FF0, 0);
        do_op("sra", 3'b011, 0, 0, 0, 0, 16'h8001, 16'h0003, 0);
        do_op("ror15", 3'b010, 0, 0, 0, 0, 16'h0001, 16'h000F, 0);
        do_op("sll k0", 3'b001, 0, 0, 0, 0, 16'hA5C3, 16'h0010, 0);
        do_op("backpressure", 3'b110, 0, 0, 0, 0, 16'hFF00, 16'h0F0F, 5);
        do_op("err", 3'b100, 0, 0, 0, 1, 16'h1234, 16'h1111, 0);
        do_op("after err", 3'b101, 0, 0, 0, 0, 16'h1200, 16'h0034, 0);
        abort("reset abort", 0, 3);
        do_op("post reset", 3'b000, 0, 0, 0, 0, 16'h8421, 16'h0005, 0);
        abort("flush abort", 1, 5);
        do_op("post flush", 3'b011, 0, 1, 0, 0, 16'h00F0, 16'h0002, 1);
        for (int i = 0; i < 60; i++)
            do_op("random", 3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 1'($urandom),
                  $urandom_range(0, 7) == 0, 16'($urandom), 16'($urandom), $urandom_range(0, 3));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
